// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Sequences every access to the external 1Mx16 SRAM and shares it between
//   the CPU port (MAR/MDR traffic) and a debug/loader port. Each transaction
//   walks IDLE -> SETUP -> ACCESS (WAIT_STATES cycles) -> DONE. When both
//   ports request at the same time, the port that was not served last wins.
//
// Parameters
//   WAIT_STATES  number of ACCESS cycles per transaction (1..15)
//   ADDR_HI      constant upper 4 bits of the 20-bit SRAM address
//
// Ports
//   Clk, Reset                     clock (rising edge), async active-low reset
//   CPU_Req/WE/Addr/WData          CPU request; held until CPU_Ready
//   CPU_Ready, CPU_RData           one-cycle completion pulse, read-data reg
//   DBG_*                          same set for the debug/loader port
//   ADDR, Data_to_SRAM             latched address / write data to the SRAM
//   Data_from_SRAM                 SRAM read data
//   Mem_CE/UB/LB/OE/WE             active-low SRAM controls
//   Busy                           high whenever the FSM is not in IDLE
//   Grant                          owner of current/last transaction (0 CPU, 1 DBG)
module sram_arbiter #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [3:0]  ADDR_HI     = 4'h0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CPU_Req,
  input  logic        CPU_WE,
  input  logic [15:0] CPU_Addr,
  input  logic [15:0] CPU_WData,
  output logic        CPU_Ready,
  output logic [15:0] CPU_RData,
  input  logic        DBG_Req,
  input  logic        DBG_WE,
  input  logic [15:0] DBG_Addr,
  input  logic [15:0] DBG_WData,
  output logic        DBG_Ready,
  output logic [15:0] DBG_RData,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic        Busy,
  output logic        Grant
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic        last_grant;
  logic        txn_we;
  logic [15:0] txn_addr;
  logic [15:0] txn_wdata;
  logic        take;
  logic        pick;
  logic        rd_capture;

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, arbitration and control decode. Every output here depends
  // only on registered state, so no Req input ever reaches a pin directly.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    pick       = 1'b0;
    Mem_CE     = 1'b1;
    Mem_UB     = 1'b1;
    Mem_LB     = 1'b1;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    CPU_Ready  = 1'b0;
    DBG_Ready  = 1'b0;
    Busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (CPU_Req || DBG_Req) begin
          take       = 1'b1;
          state_next = SETUP;
          // Tie goes to whoever was not served last; otherwise the lone requester.
          pick       = (CPU_Req && DBG_Req) ? ~last_grant : DBG_Req;
        end
      end
      SETUP: begin
        Mem_CE     = 1'b0;
        Mem_UB     = 1'b0;
        Mem_LB     = 1'b0;
        Mem_OE     = txn_we;
        state_next = ACCESS;
      end
      ACCESS: begin
        Mem_CE = 1'b0;
        Mem_UB = 1'b0;
        Mem_LB = 1'b0;
        Mem_OE = txn_we;
        Mem_WE = ~txn_we;
        if (cnt == 4'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        CPU_Ready  = ~Grant;
        DBG_Ready  = Grant;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rd_capture = (state == ACCESS) && (cnt == 4'd0) && !txn_we;

  // Transaction register, wait counter and grant bookkeeping. last_grant
  // starts at DBG so the CPU wins the very first tie.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Grant      <= 1'b0;
      last_grant <= 1'b1;
      txn_we     <= 1'b0;
      txn_addr   <= 16'h0000;
      txn_wdata  <= 16'h0000;
      cnt        <= 4'd0;
    end else begin
      if (take) begin
        Grant      <= pick;
        last_grant <= pick;
        txn_we     <= pick ? DBG_WE    : CPU_WE;
        txn_addr   <= pick ? DBG_Addr  : CPU_Addr;
        txn_wdata  <= pick ? DBG_WData : CPU_WData;
      end
      if (state == SETUP) begin
        cnt <= CNT_LOAD;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Read data lands on the edge that leaves ACCESS, into the owner's register only.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      CPU_RData <= 16'h0000;
      DBG_RData <= 16'h0000;
    end else if (rd_capture) begin
      if (Grant) begin
        DBG_RData <= Data_from_SRAM;
      end else begin
        CPU_RData <= Data_from_SRAM;
      end
    end
  end

  assign ADDR         = {ADDR_HI, txn_addr};
  assign Data_to_SRAM = txn_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: reset values, a table of single-port
// transactions, round-robin under continuous contention, a request arriving
// mid-transaction and reset asserted mid-transaction. Completions are matched
// against a queue of expected {port, rdata} records.
module tb_sram_arbiter;

  logic        Clk;
  logic        Reset;
  logic        CPU_Req, CPU_WE;
  logic [15:0] CPU_Addr, CPU_WData;
  logic        CPU_Ready;
  logic [15:0] CPU_RData;
  logic        DBG_Req, DBG_WE;
  logic [15:0] DBG_Addr, DBG_WData;
  logic        DBG_Ready;
  logic [15:0] DBG_RData;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic        Busy, Grant;

  sram_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .CPU_Req(CPU_Req), .CPU_WE(CPU_WE), .CPU_Addr(CPU_Addr), .CPU_WData(CPU_WData),
    .CPU_Ready(CPU_Ready), .CPU_RData(CPU_RData),
    .DBG_Req(DBG_Req), .DBG_WE(DBG_WE), .DBG_Addr(DBG_Addr), .DBG_WData(DBG_WData),
    .DBG_Ready(DBG_Ready), .DBG_RData(DBG_RData),
    .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .Busy(Busy), .Grant(Grant)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM model: 64K words, upper address nibble ignored (ADDR_HI is 0).
  logic [15:0] mem [0:65535];
  always @(posedge Clk) begin
    if (!Mem_CE && !Mem_WE) mem[ADDR[15:0]] <= Data_to_SRAM;
  end
  assign Data_from_SRAM = mem[ADDR[15:0]];

  typedef struct {
    bit          port;
    logic [15:0] rdata;
  } exp_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  exp_t        sb[$];
  logic [15:0] sh_rdata [2];
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Scoreboard: any Ready pulse must match the oldest outstanding expectation.
  task automatic sb_check();
    exp_t e;
    if (Reset && (CPU_Ready || DBG_Ready)) begin
      if (sb.size() == 0) begin
        fail("unexpected_ready");
      end else begin
        e = sb.pop_front();
        chk("sb_ready_port", 32'({CPU_Ready, DBG_Ready}), e.port ? 32'h1 : 32'h2);
        chk("sb_grant", 32'(Grant), 32'(e.port));
        chk("sb_rdata", e.port ? 32'(DBG_RData) : 32'(CPU_RData), 32'(e.rdata));
      end
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    sb_check();
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (port) begin
      DBG_Req = req; DBG_WE = we; DBG_Addr = addr; DBG_WData = wdata;
    end else begin
      CPU_Req = req; CPU_WE = we; CPU_Addr = addr; CPU_WData = wdata;
    end
  endtask

  task automatic run_txn(input vec_t v);
    int cyc;
    bit got;
    tick();
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    sb.push_back('{v.port, v.exp_rdata});
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      tick();
      cyc++;
      if (cyc <= 3) begin
        chk("txn_ce", 32'(Mem_CE), 32'h0);
        chk("txn_oe", 32'(Mem_OE), 32'(v.we));
        chk("txn_we", 32'(Mem_WE), (cyc >= 2) ? 32'(!v.we) : 32'h1);
      end
      if (cyc == 1) begin
        chk("txn_addr", 32'(ADDR), 32'({4'h0, v.addr}));
        if (v.we) chk("txn_wdata", 32'(Data_to_SRAM), 32'(v.wdata));
      end
      if (v.port ? DBG_Ready : CPU_Ready) got = 1'b1;
    end
    if (!got) fail("txn_timeout");
    chk("txn_latency", 32'(cyc), 32'd4);
    chk("done_ctrl", 32'({Mem_CE, Mem_OE, Mem_WE}), 32'h7);
    chk("other_rdata", v.port ? 32'(CPU_RData) : 32'(DBG_RData), 32'(sh_rdata[!v.port]));
    chk("addr_hold", 32'(ADDR), 32'({4'h0, v.addr}));
    sh_rdata[v.port] = v.exp_rdata;
    drive(v.port, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    chk("post_idle", 32'({Busy, CPU_Ready, DBG_Ready}), 32'h0);
  endtask

  vec_t vecs [12];

  initial begin
    int n_rdy;
    int last_cyc;
    int cyc;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    sh_rdata[0] = 16'h0;
    sh_rdata[1] = 16'h0;
    Reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

    //                port  we    addr      wdata     exp_rdata
    vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[2]  = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[4]  = '{1'b0, 1'b1, 16'h0030, 16'hA5A5, 16'hBEEF};
    vecs[5]  = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234};
    vecs[6]  = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'hA5A5};
    vecs[7]  = '{1'b0, 1'b1, 16'h00FF, 16'h0001, 16'h1234};
    vecs[8]  = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h0001};
    vecs[9]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 16'hFF10, 16'hC0DE, 16'h0001};
    vecs[11] = '{1'b1, 1'b0, 16'hFF10, 16'h0000, 16'hC0DE};

    // Reset values
    repeat (2) @(negedge Clk);
    chk("rst_addr", 32'(ADDR), 32'h0);
    chk("rst_wdata", 32'(Data_to_SRAM), 32'h0);
    chk("rst_rdata", 32'({CPU_RData, DBG_RData}), 32'h0);
    chk("rst_ctrl", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'h1F);
    chk("rst_status", 32'({CPU_Ready, DBG_Ready, Busy, Grant}), 32'h0);
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_busy", 32'(Busy), 32'h0);
      chk("idle_ce", 32'(Mem_CE), 32'h1);
    end

    // Table of single-port transactions
    for (int i = 0; i < 12; i++) run_txn(vecs[i]);

    // Continuous contention: last served was DBG, so CPU leads
    tick();
    drive(1'b0, 1'b1, 1'b1, 16'h0050, 16'h1111);
    drive(1'b1, 1'b1, 1'b1, 16'h0060, 16'h2222);
    for (int i = 0; i < 4; i++) sb.push_back('{bit'(i % 2), sh_rdata[i % 2]});
    n_rdy = 0;
    last_cyc = 0;
    cyc = 0;
    while (n_rdy < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (CPU_Ready || DBG_Ready) begin
        chk("rr_interval", 32'(cyc - last_cyc), (n_rdy == 0) ? 32'd4 : 32'd5);
        last_cyc = cyc;
        n_rdy++;
        if (n_rdy == 4) begin
          drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
          drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        end
      end else if (n_rdy > 0 && cyc == last_cyc + 1) begin
        chk("rr_pulse_width", 32'(Busy), 32'h0);
      end
    end
    chk("rr_count", 32'(n_rdy), 32'd4);
    tick();
    chk("rr_quiet", 32'({Busy, CPU_Ready, DBG_Ready}), 32'h0);

    // DBG request arriving while a CPU read is in ACCESS
    tick();
    drive(1'b0, 1'b1, 1'b0, 16'h0050, 16'h0);
    sb.push_back('{1'b0, 16'h1111});
    tick();
    tick();
    chk("pend_access", 32'({Mem_CE, Grant}), 32'h0);
    drive(1'b1, 1'b1, 1'b1, 16'h0070, 16'h3333);
    sb.push_back('{1'b1, sh_rdata[1]});
    tick();
    tick();
    chk("pend_cpu_ready", 32'(CPU_Ready), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    sh_rdata[0] = 16'h1111;
    tick();
    chk("pend_gap_idle", 32'({Mem_CE, Busy}), 32'h2);
    tick();
    chk("pend_dbg_setup", 32'({Mem_CE, Grant, Mem_OE}), 32'h3);
    cyc = 0;
    while (!DBG_Ready && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("pend_dbg_latency", 32'(cyc), 32'd3);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    chk("pend_mem", 32'(mem[16'h0070]), 32'h3333);

    // Reset in the second ACCESS cycle of a DBG write
    tick();
    drive(1'b1, 1'b1, 1'b1, 16'h0080, 16'h4444);
    sb.push_back('{1'b1, sh_rdata[1]});
    tick();
    tick();
    tick();
    chk("rst_mid_we_low", 32'({Mem_CE, Mem_WE}), 32'h0);
    Reset = 1'b0;
    #1;
    chk("rst_mid_ctrl", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Busy}), 32'h3E);
    chk("rst_mid_rdata", 32'({CPU_RData, DBG_RData}), 32'h0);
    sb.delete();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    sh_rdata[0] = 16'h0;
    sh_rdata[1] = 16'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_mid_no_ready", 32'({CPU_Ready, DBG_Ready}), 32'h0);
    end
    Reset = 1'b1;
    run_txn('{1'b0, 1'b0, 16'h0050, 16'h0000, 16'h1111});

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequences every access to the external 1Mx16 SRAM and shares it between two requesters: the SLC-3 CPU port (MAR/MDR traffic) and a debug/loader port used to preload or inspect memory. Each request runs as a multi-cycle transaction. The block drives the active-low chip controls and the 20-bit address, and it sits between the requesters and the Mem2IO/tristate path. Arbitration is round-robin, and each requester receives a one-cycle ready pulse when its transaction completes.

## Interface
Parameters:
- WAIT_STATES, 2, number of ACCESS cycles per transaction; legal range 1..15 (4-bit counter)
- ADDR_HI, 4'h0, constant upper 4 bits of ADDR

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- CPU_Req  in  1  CPU request; held until CPU_Ready
- CPU_WE  in  1  1 = write, 0 = read
- CPU_Addr  in  16  word address
- CPU_WData  in  16  write data
- CPU_Ready  out  1  one-cycle completion pulse
- CPU_RData  out  16  read-data register
- DBG_Req, DBG_WE, DBG_Addr, DBG_WData, DBG_Ready, DBG_RData: same as the CPU_* ports, for the debug port
- ADDR  out  20  {ADDR_HI, latched address}
- Data_to_SRAM  out  16  latched write data
- Data_from_SRAM  in  16  SRAM read data
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  active-low SRAM controls
- Busy  out  1  high in any state other than IDLE
- Grant  out  1  0 = CPU owns the current/last transaction, 1 = DBG

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - Samples CPU_Req and DBG_Req.
  - If only one is asserted, that requester is granted.
  - If both are asserted, the requester that was not granted last wins. The last-grant register resets to DBG, so the CPU wins the first tie.
  - On grant, the block latches WE, Addr and WData from the winner into the transaction register, updates Grant, and moves to SETUP.
- SETUP (1 cycle):
  - Mem_CE=0, Mem_UB=0, Mem_LB=0.
  - Mem_OE=0 for a read, 1 for a write.
  - Mem_WE=1.
  - Counter loaded with WAIT_STATES-1.
- ACCESS (WAIT_STATES cycles):
  - Same controls as SETUP, except Mem_WE=0 for a write.
  - The counter decrements each cycle. When it reaches 0, the state moves to DONE.
  - Read: on that same edge, Data_from_SRAM is captured into the granted requester's RData. The other requester's RData is unchanged.
- DONE (1 cycle):
  - Mem_WE=1, Mem_OE=1, Mem_CE=1.
  - The granted requester's Ready=1; the other Ready=0.
  - Next state is IDLE.
- Requester protocol:
  - Req, WE, Addr and WData must stay stable until Ready is seen.
  - Req must drop in the cycle after Ready, or a new back-to-back request is sampled in the following IDLE.
- RData is never modified by writes.
- ADDR and Data_to_SRAM hold their last latched values between transactions.
- All SRAM controls, Ready and Busy are decoded from registered state only. There is no combinational path from any Req input to any output.

## Timing
- Reset values: state=IDLE, ADDR={ADDR_HI,16'h0}, Data_to_SRAM=0, CPU_RData=DBG_RData=0, Mem_CE/UB/LB/OE/WE=1, CPU_Ready=DBG_Ready=0, Busy=0, Grant=0, last-grant=DBG.
- Latency: if Req is sampled in IDLE at edge 0, then SETUP is cycle 1, ACCESS is cycles 2..WAIT_STATES+1, DONE (Ready high) is cycle WAIT_STATES+2, and IDLE is cycle WAIT_STATES+3. With the default, Ready arrives 4 cycles after the sampling edge.
- Throughput: a back-to-back request is sampled one cycle after DONE. Each transaction occupies WAIT_STATES+3 cycles.
- Mem_WE is low only during ACCESS. Address and data are stable for one full cycle before WE falls and until after WE rises.
- Requests arriving in SETUP, ACCESS or DONE are not sampled. They are held by the requester and arbitrated at the next IDLE.
- Simultaneous requests while alternating: CPU, DBG, CPU, ... with no starvation.
- Reset asserted mid-transaction:
  - All controls go inactive asynchronously and the state returns to IDLE.
  - No Ready pulse is produced and the RData registers are cleared.
  - The transaction is dropped.
- WAIT_STATES outside 1..15 is unsupported; no checking is required in RTL.

## Test plan
- Reset with all requests low -> every output holds its reset value. After reset release, no Req for 10 cycles -> Busy=0, Mem_CE=1.
- CPU write Addr=16'h0010, WData=16'hBEEF -> SETUP, then Mem_WE=0 for exactly 2 cycles with ADDR=20'h00010 and Data_to_SRAM=16'hBEEF; CPU_Ready high in cycle 4; DBG_Ready stays 0.
- CPU read 16'h0010 with the SRAM model returning 16'hBEEF -> Mem_OE=0 during SETUP/ACCESS; CPU_RData=16'hBEEF in the CPU_Ready cycle; DBG_RData unchanged.
- CPU_Req and DBG_Req held high continuously for 4 transactions -> Grant sequence 0,1,0,1; each Ready pulse is exactly 1 cycle, every 5 cycles.
- DBG_Req rises while a CPU access is in ACCESS -> DBG is granted in the first IDLE after the CPU DONE, with no overlap of CE activity.
- Reset pulled low in the second ACCESS cycle of a DBG write -> Mem_WE=1 and Mem_CE=1 immediately; no DBG_Ready; after release, a new CPU request completes normally in 4 cycles.
